// File: rtl/cs_pkg.sv
// Shared constants for the CS series core and its downstream stages.
package cs_pkg;

  localparam int CS_XW  = 8;   // X sample width
  localparam int CS_YW  = 10;  // Y result width
  localparam int CS_WIN = 9;   // X samples needed before the first valid Y

endpackage

// File: rtl/cs_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Occupancy is tracked by an explicit count, so pointers only need to wrap
// modulo DEPTH and full/empty are never ambiguous.
module cs_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [FW-1:0] cnt;
  logic          pop_ok;
  logic          push_ok;

  // Qualify requests against occupancy; a full FIFO accepts a push only
  // when the head leaves on the same edge.
  always_comb begin
    empty   = (cnt == '0);
    full    = (cnt == FW'(DEPTH));
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    rd_nxt  = rd_ptr + 1'b1;
    fill    = cnt;
  end

  // Storage, pointers, occupancy and the head register.
  // The head register is reloaded from the entry behind the popped one, or
  // straight from din when that entry is the one being written this edge,
  // and otherwise holds so an empty FIFO keeps showing its last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_nxt;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (pop_ok) begin
        if (cnt > FW'(1))  dout <= mem[rd_nxt];
        else if (push_ok)  dout <= din;
      end else if (push_ok && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/cs_y_collector.sv
// Collects valid CS Y results after the warm-up window into a FIFO and
// presents them on a valid/ready stream, flagging and counting drops.
module cs_y_collector
  import cs_pkg::*;
#(
  parameter int DW     = CS_YW,
  parameter int DEPTH  = 8,
  parameter int WARMUP = CS_WIN,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       x_strobe,
  input  logic [DW-1:0]              y_in,
  output logic [DW-1:0]              out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       overflow,
  output logic [CNT_W-1:0]           sample_cnt
);

  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WW-1:0] WMAX = WW'(WARMUP - 1);

  logic          strobe_d;
  logic [WW-1:0] wcnt;
  logic          capture;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;

  // Capture decision and push acceptance for the current edge.
  always_comb begin
    out_valid = ~empty;
    pop       = out_valid & out_ready;
    capture   = strobe_d & (wcnt == WMAX);
    push      = capture & (~full | pop);
  end

  // Warm-up tracking, drop flag and accepted-result counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_d   <= 1'b0;
      wcnt       <= '0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else if (clear) begin
      strobe_d   <= 1'b0;
      wcnt       <= '0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      strobe_d <= x_strobe;
      if (strobe_d && wcnt != WMAX) wcnt <= wcnt + 1'b1;
      if (capture && !push) overflow <= 1'b1;
      if (push && sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
    end
  end

  cs_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (y_in),
    .dout  (out_data),
    .empty (empty),
    .full  (full),
    .fill  (fill)
  );

endmodule

// File: tb/tb_cs_y_collector.sv
// Bench for cs_y_collector: directed scenarios plus a random phase, all
// checked every cycle against a queue-based model of the collector.
module tb_cs_y_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        x_strobe;
  logic [9:0]  y_in;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fill;
  logic        overflow;
  logic [15:0] sample_cnt;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [9:0] q[$];
  int         m_nstr;
  bit         m_sd;
  bit         m_ovf;
  int         m_cnt;
  logic [9:0] m_head;

  always #5 clk = ~clk;

  cs_y_collector #(
    .DW     (10),
    .DEPTH  (8),
    .WARMUP (9),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .x_strobe   (x_strobe),
    .y_in       (y_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill       (fill),
    .overflow   (overflow),
    .sample_cnt (sample_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_nstr = 0;
    m_sd   = 0;
    m_ovf  = 0;
    m_cnt  = 0;
    m_head = '0;
  endtask

  // One clock edge of the collector's intended behaviour, from the inputs
  // present at that edge.
  task automatic model_edge();
    bit cap, pp, room;
    if (clear) begin
      model_reset();
    end else begin
      cap = m_sd && (m_nstr >= 8);
      if (m_sd) m_nstr++;
      pp   = (q.size() > 0) && out_ready;
      room = (q.size() < 8) || pp;
      if (pp) void'(q.pop_front());
      if (cap) begin
        if (room) begin
          q.push_back(y_in);
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
      m_sd = x_strobe;
      if (q.size() > 0) m_head = q[0];
    end
  endtask

  task automatic check_all();
    chk("out_valid",  32'(out_valid),  32'(q.size() > 0));
    chk("out_data",   32'(out_data),   32'(m_head));
    chk("fill",       32'(fill),       32'(q.size()));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [9:0] last;
    reset = 1'b0; clear = 1'b0; x_strobe = 1'b0; y_in = '0; out_ready = 1'b0;
    model_reset();
    #2;
    check_all();
    #10 reset = 1'b1;

    // Eight strobes during warm-up push nothing; the ninth captures 12A.
    for (int i = 0; i < 8; i++) begin
      x_strobe = 1'b1; y_in = 10'h3FF; step();
      x_strobe = 1'b0; step();
      chk("warmup_fill", 32'(fill), 32'd0);
    end
    x_strobe = 1'b1; step();
    x_strobe = 1'b0; y_in = 10'h12A; step();
    chk("first_fill", 32'(fill), 32'd1);
    chk("first_data", 32'(out_data), 32'h12A);

    // Drain, then ten back-to-back captures with no consumer.
    out_ready = 1'b1; step();
    out_ready = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      x_strobe = (j <= 10);
      y_in     = 10'(j - 1);
      step();
    end
    chk("ovf_fill", 32'(fill), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_cnt",  32'(sample_cnt), 32'd9);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_order", 32'(out_data), 32'(k));
      step();
    end
    out_ready = 1'b0;

    // Full FIFO with simultaneous pop and capture keeps both.
    clear = 1'b1; step(); clear = 1'b0;
    for (int j = 0; j < 17; j++) begin
      x_strobe = 1'b1; y_in = 10'($urandom_range(0, 1023)); step();
    end
    chk("full_fill", 32'(fill), 32'd8);
    x_strobe = 1'b0; y_in = 10'h2AA; out_ready = 1'b1; step();
    chk("pp_full_fill", 32'(fill), 32'd8);
    chk("pp_full_ovf",  32'(overflow), 32'd0);
    last = '0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) last = out_data;
      step();
    end
    chk("pp_full_last", 32'(last), 32'h2AA);

    // Streaming with a ready consumer.
    clear = 1'b1; step(); clear = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 108; j++) begin
      x_strobe = 1'b1; y_in = 10'($urandom_range(0, 1023)); step();
      chk("stream_fill_le1", 32'(fill <= 4'd1), 32'd1);
    end
    x_strobe = 1'b0; step();
    chk("stream_cnt", 32'(sample_cnt), 32'd100);

    // Async reset mid-cycle with fill=5.
    clear = 1'b1; step(); clear = 1'b0;
    out_ready = 1'b0;
    for (int j = 0; j < 13; j++) begin
      x_strobe = 1'b1; y_in = 10'($urandom_range(0, 1023)); step();
    end
    x_strobe = 1'b0; step();
    chk("pre_rst_fill", 32'(fill), 32'd5);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_fill",  32'(fill), 32'd0);
    chk("arst_ovf",   32'(overflow), 32'd0);
    chk("arst_cnt",   32'(sample_cnt), 32'd0);
    chk("arst_data",  32'(out_data), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    check_all();

    // Clear with fill=5 and warm-up complete restarts the warm-up.
    for (int j = 0; j < 13; j++) begin
      x_strobe = 1'b1; y_in = 10'($urandom_range(0, 1023)); step();
    end
    x_strobe = 1'b0; step();
    chk("pre_clr_fill", 32'(fill), 32'd5);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_fill", 32'(fill), 32'd0);
    for (int i = 0; i < 8; i++) begin
      x_strobe = 1'b1; y_in = 10'($urandom_range(0, 1023)); step();
      x_strobe = 1'b0; step();
      chk("clr_warm_fill", 32'(fill), 32'd0);
    end
    x_strobe = 1'b1; step();
    x_strobe = 1'b0; y_in = 10'h155; step();
    chk("clr_ninth_fill", 32'(fill), 32'd1);
    chk("clr_ninth_data", 32'(out_data), 32'h155);

    // Random traffic.
    for (int j = 0; j < 400; j++) begin
      x_strobe  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      y_in      = 10'($urandom_range(0, 1023));
      clear     = ($urandom_range(0, 99) == 0);
      step();
    end
    clear = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
